// File: rtl/truth_table_checker_if.sv
// ----------------------------------------------------------------------------
// truth_table_checker_if
//   Bundles the request/result signals of truth_table_checker.
//   master : test driver side (drives start, exp_table and the function output)
//   slave  : checker side (drives the vector sweep and the results)
//
//   start      run request, accepted only while the checker is idle
//   exp_table  expected outputs, bit i = f(vector i)
//   fn_out     output of the function under test
//   vec_out    function inputs, MSB first {X,Y,W,Z}
//   busy       sweep in progress
//   done       one-cycle completion pulse
//   table_out  captured truth table
//   pass       table_out matched the expected table
//   fail_idx   lowest mismatching row, 0 when pass
// ----------------------------------------------------------------------------
interface truth_table_checker_if #(
  parameter int N_IN = 4
) ();
  localparam int D = 1 << N_IN;

  logic            start;
  logic [D-1:0]    exp_table;
  logic            fn_out;
  logic [N_IN-1:0] vec_out;
  logic            busy;
  logic            done;
  logic [D-1:0]    table_out;
  logic            pass;
  logic [N_IN-1:0] fail_idx;

  modport master (
    output start, exp_table, fn_out,
    input  vec_out, busy, done, table_out, pass, fail_idx
  );

  modport slave (
    input  start, exp_table, fn_out,
    output vec_out, busy, done, table_out, pass, fail_idx
  );
endinterface

// File: rtl/truth_table_checker.sv
// ----------------------------------------------------------------------------
// truth_table_checker
//   Capture/check stage for an N_IN-input combinational function block.
//   One start request sweeps every input vector onto the block, holds each
//   vector SETTLE cycles, samples the block output into a truth table and then
//   compares the table against the expected table latched at start.
//
//   Ports:
//     clk    single clock, rising edge
//     rst_n  synchronous, active-low reset
//     bus    truth_table_checker_if.slave (start/exp_table/fn_out in,
//            vec_out/busy/done/table_out/pass/fail_idx out)
//   The interface instance must be built with the same N_IN as this module.
// ----------------------------------------------------------------------------
module truth_table_checker #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_checker_if.slave  bus
);

  localparam int D     = 1 << N_IN;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [N_IN-1:0]  IDX_ONE     = N_IN'(1);
  localparam logic [N_IN-1:0]  IDX_LAST    = N_IN'(D - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    CHECK  = 2'd3
  } state_e;

  state_e           state_q,    state_d;
  logic [N_IN-1:0]  idx_q,      idx_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [D-1:0]     exp_q,      exp_d;
  logic [D-1:0]     table_q,    table_d;
  logic             pass_q,     pass_d;
  logic [N_IN-1:0]  fail_idx_q, fail_idx_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic [D-1:0]     mism;

  // Index of the lowest set bit; scanning downward lets the lowest hit win.
  function automatic logic [N_IN-1:0] lowest_set(input logic [D-1:0] v);
    lowest_set = '0;
    for (int i = D - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = N_IN'(i);
    end
  endfunction

  // NOTE: every variable gets its default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    table_d    = table_q;
    pass_d     = pass_q;
    fail_idx_d = fail_idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mism       = table_q ^ exp_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          exp_d      = bus.exp_table;
          table_d    = '0;
          pass_d     = 1'b0;
          fail_idx_d = '0;
          idx_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = APPLY;
        end
      end

      // vec_out is idx_q itself, so the vector is already stable on entry.
      APPLY: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // The last row does not advance idx, so vec_out parks on D-1.
      SAMPLE: begin
        table_d[idx_q] = bus.fn_out;
        if (idx_q == IDX_LAST) begin
          state_d = CHECK;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = APPLY;
        end
      end

      CHECK: begin
        pass_d     = (mism == '0);
        fail_idx_d = lowest_set(mism);
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values and the update order inside the block is moot.
  // NOTE: the table is a plain register vector, not a memory, so it is cleared
  // by reset like any other flop; a mid-run reset leaves no partial results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      exp_q      <= '0;
      table_q    <= '0;
      pass_q     <= 1'b0;
      fail_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      table_q    <= table_d;
      pass_q     <= pass_d;
      fail_idx_q <= fail_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.vec_out   = idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.table_out = table_q;
  assign bus.pass      = pass_q;
  assign bus.fail_idx  = fail_idx_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// ----------------------------------------------------------------------------
// tb_truth_table_checker
//   Drives two checkers (SETTLE=1 and SETTLE=3) whose function block is a
//   behavioural model: PoS with maxterms 0-7,15 (table 16'h7F00) or 4-input
//   parity (table 16'h6996), chosen by fn_sel.
// ----------------------------------------------------------------------------
module tb_truth_table_checker;

  localparam int N_IN = 4;
  localparam int D    = 1 << N_IN;

  logic clk = 1'b0;
  logic rst_n;
  logic fn_sel;

  always #5 clk = ~clk;

  truth_table_checker_if #(.N_IN(N_IN)) bus1 ();
  truth_table_checker_if #(.N_IN(N_IN)) bus3 ();

  function automatic logic fn_model(input logic [3:0] v, input logic sel);
    if (sel) return ^v;
    return v[3] & ~(&v);
  endfunction

  assign bus1.fn_out = fn_model(bus1.vec_out, fn_sel);
  assign bus3.fn_out = fn_model(bus3.vec_out, 1'b0);

  truth_table_checker #(.N_IN(N_IN), .SETTLE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  truth_table_checker #(.N_IN(N_IN), .SETTLE(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        sel;
    logic [15:0] exp;
    logic        pass;
    logic [3:0]  fidx;
    logic [15:0] tbl;
    int          glitch;
  } vec_t;

  vec_t vecs[7];

  // One sweep on dut1 (SETTLE=1). Accepting edge is edge 0; the loop covers
  // 40 edges so a late or missing done is caught without hanging.
  task automatic run_once(input logic [15:0] exp, input int glitch,
                          output int done_edge, output int n_done,
                          output int busy_err, output int vec_err);
    int ev;
    done_edge = -1;
    n_done    = 0;
    busy_err  = 0;
    vec_err   = 0;
    bus1.exp_table = exp;
    bus1.start     = 1'b1;
    tick();
    bus1.start     = 1'b0;
    bus1.exp_table = ~exp;  // must be ignored: only the latched value counts
    if (bus1.busy !== 1'b1) busy_err++;
    if (bus1.vec_out !== 4'd0) vec_err++;
    for (int e = 1; e <= 40; e++) begin
      bus1.start = (e == glitch);
      if (e == glitch) bus1.exp_table = 16'h0000;
      tick();
      if (bus1.done === 1'b1) begin
        n_done++;
        if (done_edge < 0) done_edge = e;
      end
      if (bus1.busy !== (e < 33)) busy_err++;
      ev = (e / 2 > 15) ? 15 : e / 2;
      if (bus1.vec_out !== 4'(ev)) vec_err++;
    end
    bus1.start = 1'b0;
  endtask

  initial begin
    int done_edge, n_done, busy_err, vec_err, e, ev;

    vecs[0] = '{1'b0, 16'h7F00,          1'b1, 4'd0,  16'h7F00, 0};
    vecs[1] = '{1'b0, 16'h7F00 ^ 16'h8004, 1'b0, 4'd2, 16'h7F00, 0};
    vecs[2] = '{1'b0, 16'h7F00,          1'b1, 4'd0,  16'h7F00, 10};
    vecs[3] = '{1'b0, 16'h7F01,          1'b0, 4'd0,  16'h7F00, 0};
    vecs[4] = '{1'b1, 16'h6996,          1'b1, 4'd0,  16'h6996, 0};
    vecs[5] = '{1'b1, 16'h6990,          1'b0, 4'd1,  16'h6996, 0};
    vecs[6] = '{1'b0, 16'hFF00,          1'b0, 4'd15, 16'h7F00, 0};

    // Reset with start held high: nothing may start.
    rst_n          = 1'b0;
    fn_sel         = 1'b0;
    bus1.start     = 1'b1;
    bus1.exp_table = 16'h7F00;
    bus3.start     = 1'b1;
    bus3.exp_table = 16'h7F00;
    tick();
    check("reset_busy_edge1", bus1.busy, 0);
    tick();
    check("reset_busy_edge2", bus1.busy, 0);
    check("reset_vec_out", bus1.vec_out, 0);
    check("reset_done", bus1.done, 0);
    check("reset_table_out", bus1.table_out, 0);
    check("reset_pass", bus1.pass, 0);
    check("reset_fail_idx", bus1.fail_idx, 0);
    check("reset_busy_settle3", bus3.busy, 0);
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    rst_n      = 1'b1;
    tick();
    check("idle_after_reset_busy", bus1.busy, 0);

    // Table-driven sweeps.
    foreach (vecs[i]) begin
      fn_sel = vecs[i].sel;
      run_once(vecs[i].exp, vecs[i].glitch, done_edge, n_done, busy_err, vec_err);
      check($sformatf("v%0d_done_edge", i), done_edge, 33);
      check($sformatf("v%0d_done_count", i), n_done, 1);
      check($sformatf("v%0d_busy_trace_errs", i), busy_err, 0);
      check($sformatf("v%0d_vec_trace_errs", i), vec_err, 0);
      check($sformatf("v%0d_table_out", i), bus1.table_out, vecs[i].tbl);
      check($sformatf("v%0d_pass", i), bus1.pass, vecs[i].pass);
      check($sformatf("v%0d_fail_idx", i), bus1.fail_idx, vecs[i].fidx);
    end
    fn_sel = 1'b0;

    // Start presented in the done-pulse cycle is accepted.
    bus1.exp_table = 16'h7F00;
    bus1.start     = 1'b1;
    tick();
    bus1.start = 1'b0;
    e = 0;
    while (bus1.done !== 1'b1 && e < 60) begin
      tick();
      e++;
    end
    check("b2b_first_done_edge", e, 33);
    check("b2b_first_pass", bus1.pass, 1);
    bus1.exp_table = 16'hFF00;
    bus1.start     = 1'b1;
    tick();
    bus1.start = 1'b0;
    check("b2b_accept_busy", bus1.busy, 1);
    check("b2b_accept_done_low", bus1.done, 0);
    check("b2b_accept_table_cleared", bus1.table_out, 0);
    check("b2b_accept_pass_cleared", bus1.pass, 0);
    check("b2b_accept_vec_out", bus1.vec_out, 0);
    e = 0;
    while (bus1.done !== 1'b1 && e < 60) begin
      tick();
      e++;
    end
    check("b2b_second_done_edge", e, 33);
    check("b2b_second_pass", bus1.pass, 0);
    check("b2b_second_fail_idx", bus1.fail_idx, 15);
    check("b2b_second_table_out", bus1.table_out, 16'h7F00);
    tick();
    check("b2b_done_one_cycle", bus1.done, 0);
    check("b2b_results_hold", bus1.fail_idx, 15);
    check("b2b_vec_parks_last", bus1.vec_out, 15);

    // Reset at edge 20 of a sweep aborts it.
    bus1.exp_table = 16'h7F00;
    bus1.start     = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int k = 1; k <= 19; k++) tick();
    check("abort_busy_before", bus1.busy, 1);
    check("abort_partial_table", bus1.table_out, 16'h0100);
    rst_n = 1'b0;
    tick();
    check("abort_busy", bus1.busy, 0);
    check("abort_vec_out", bus1.vec_out, 0);
    check("abort_table_out", bus1.table_out, 0);
    check("abort_done", bus1.done, 0);
    check("abort_pass", bus1.pass, 0);
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus1.done === 1'b1) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_stays_idle", bus1.busy, 0);
    run_once(16'h7F00, 0, done_edge, n_done, busy_err, vec_err);
    check("post_abort_done_edge", done_edge, 33);
    check("post_abort_done_count", n_done, 1);
    check("post_abort_table_out", bus1.table_out, 16'h7F00);
    check("post_abort_pass", bus1.pass, 1);

    // SETTLE=3: each vector held 3 cycles plus the sample cycle.
    bus3.exp_table = 16'h7F00;
    bus3.start     = 1'b1;
    tick();
    bus3.start = 1'b0;
    done_edge = -1;
    n_done    = 0;
    vec_err   = 0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (bus3.done === 1'b1) begin
        n_done++;
        if (done_edge < 0) done_edge = k;
      end
      ev = (k / 4 > 15) ? 15 : k / 4;
      if (bus3.vec_out !== 4'(ev)) vec_err++;
    end
    check("s3_done_edge", done_edge, 65);
    check("s3_done_count", n_done, 1);
    check("s3_vec_trace_errs", vec_err, 0);
    check("s3_table_out", bus3.table_out, 16'h7F00);
    check("s3_pass", bus3.pass, 1);
    check("s3_fail_idx", bus3.fail_idx, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
